// File: rtl/mmr_axil_regfile.sv
// AXI4-Lite slave register file: NREGS registers, each read-write (software
// storage) or read-only (live fabric value), with byte strobes, per-register
// read/write event pulses and SLVERR on illegal accesses.
//
// Ports:
//   clock, reset            sole clock, synchronous active-high reset
//   s_aw* / s_w* / s_b*     AXI-Lite write address, data and response channels
//   s_ar* / s_r*            AXI-Lite read address and data channels
//   hw_data                 live values for read-only registers (RW slices ignored)
//   reg_data                registered contents of RW registers (RO slices 0)
//   wr_pulse / rd_pulse     one-cycle event per successful write / read
module mmr_axil_regfile #(
    parameter int unsigned           NREGS       = 16,
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter int unsigned           ADDR_WIDTH  = 12,
    parameter logic [NREGS-1:0]      RW_MASK     = {NREGS{1'b1}},
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [ADDR_WIDTH-1:0]       s_awaddr,
    input  logic                        s_awvalid,
    output logic                        s_awready,
    input  logic [DATA_WIDTH-1:0]       s_wdata,
    input  logic [DATA_WIDTH/8-1:0]     s_wstrb,
    input  logic                        s_wvalid,
    output logic                        s_wready,
    output logic [1:0]                  s_bresp,
    output logic                        s_bvalid,
    input  logic                        s_bready,
    input  logic [ADDR_WIDTH-1:0]       s_araddr,
    input  logic                        s_arvalid,
    output logic                        s_arready,
    output logic [DATA_WIDTH-1:0]       s_rdata,
    output logic [1:0]                  s_rresp,
    output logic                        s_rvalid,
    input  logic                        s_rready,
    input  logic [NREGS*DATA_WIDTH-1:0] hw_data,
    output logic [NREGS*DATA_WIDTH-1:0] reg_data,
    output logic [NREGS-1:0]            wr_pulse,
    output logic [NREGS-1:0]            rd_pulse
);

    localparam int unsigned NBYTES   = DATA_WIDTH / 8;
    localparam int unsigned ADDR_LSB = $clog2(NBYTES);
    localparam int unsigned IDX_W    = ADDR_WIDTH - ADDR_LSB;
    localparam int unsigned BUS_W    = NREGS * DATA_WIDTH;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Reset image: RW slices take RESET_VALUE, RO slices stay zero.
    function automatic logic [BUS_W-1:0] reset_image();
        logic [BUS_W-1:0] img;
        img = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            if (RW_MASK[i]) begin
                img[i*DATA_WIDTH +: DATA_WIDTH] = RESET_VALUE;
            end
        end
        return img;
    endfunction

    localparam logic [BUS_W-1:0] REG_RESET = reset_image();

    typedef enum logic { W_IDLE, W_RESP } w_state_t;
    typedef enum logic { R_IDLE, R_DATA } r_state_t;

    w_state_t               w_state, w_state_n;
    r_state_t               r_state, r_state_n;

    logic                   aw_held, aw_held_n;
    logic                   w_held, w_held_n;
    logic [IDX_W-1:0]       awidx_q, awidx_n;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_n;
    logic [NBYTES-1:0]      wstrb_q, wstrb_n;

    logic                   awready_n, wready_n, bvalid_n, arready_n, rvalid_n;
    logic [1:0]             bresp_n, rresp_n;
    logic [DATA_WIDTH-1:0]  rdata_n;
    logic [BUS_W-1:0]       reg_data_n;
    logic [NREGS-1:0]       wr_pulse_n, rd_pulse_n;

    logic                   aw_hs, w_hs, ar_hs;
    logic [IDX_W-1:0]       widx, ridx;
    logic [DATA_WIDTH-1:0]  wdata_eff;
    logic [NBYTES-1:0]      wstrb_eff;
    logic                   w_ok, r_hit;

    // Low address bits select bytes within a register and carry no meaning here.
    logic                   unused_bits;
    assign unused_bits = &{1'b0, s_awaddr[ADDR_LSB-1:0], s_araddr[ADDR_LSB-1:0]};

    assign aw_hs = s_awvalid && s_awready;
    assign w_hs  = s_wvalid && s_wready;
    assign ar_hs = s_arvalid && s_arready;

    // A beat held from an earlier cycle takes precedence over the live bus.
    assign widx      = aw_held ? awidx_q : s_awaddr[ADDR_WIDTH-1:ADDR_LSB];
    assign wdata_eff = w_held ? wdata_q : s_wdata;
    assign wstrb_eff = w_held ? wstrb_q : s_wstrb;
    assign ridx      = s_araddr[ADDR_WIDTH-1:ADDR_LSB];

    // State and output registers for both channels.
    always_ff @(posedge clock) begin
        if (reset) begin
            w_state   <= W_IDLE;
            r_state   <= R_IDLE;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            awidx_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            s_awready <= 1'b0;
            s_wready  <= 1'b0;
            s_bvalid  <= 1'b0;
            s_bresp   <= 2'b00;
            s_arready <= 1'b0;
            s_rvalid  <= 1'b0;
            s_rresp   <= 2'b00;
            s_rdata   <= '0;
            reg_data  <= REG_RESET;
            wr_pulse  <= '0;
            rd_pulse  <= '0;
        end else begin
            w_state   <= w_state_n;
            r_state   <= r_state_n;
            aw_held   <= aw_held_n;
            w_held    <= w_held_n;
            awidx_q   <= awidx_n;
            wdata_q   <= wdata_n;
            wstrb_q   <= wstrb_n;
            s_awready <= awready_n;
            s_wready  <= wready_n;
            s_bvalid  <= bvalid_n;
            s_bresp   <= bresp_n;
            s_arready <= arready_n;
            s_rvalid  <= rvalid_n;
            s_rresp   <= rresp_n;
            s_rdata   <= rdata_n;
            reg_data  <= reg_data_n;
            wr_pulse  <= wr_pulse_n;
            rd_pulse  <= rd_pulse_n;
        end
    end

    // Write channel: collect AW and W in any order, commit when both are held.
    always_comb begin
        w_state_n  = w_state;
        aw_held_n  = aw_held;
        w_held_n   = w_held;
        awidx_n    = awidx_q;
        wdata_n    = wdata_q;
        wstrb_n    = wstrb_q;
        awready_n  = s_awready;
        wready_n   = s_wready;
        bvalid_n   = s_bvalid;
        bresp_n    = s_bresp;
        wr_pulse_n = '0;
        reg_data_n = reg_data;
        w_ok       = 1'b0;

        case (w_state)
            W_IDLE: begin
                if (aw_hs) begin
                    awidx_n = s_awaddr[ADDR_WIDTH-1:ADDR_LSB];
                end
                if (w_hs) begin
                    wdata_n = s_wdata;
                    wstrb_n = s_wstrb;
                end
                if ((aw_held || aw_hs) && (w_held || w_hs)) begin
                    for (int unsigned i = 0; i < NREGS; i++) begin
                        if (RW_MASK[i] && (widx == IDX_W'(i))) begin
                            w_ok          = 1'b1;
                            wr_pulse_n[i] = 1'b1;
                            for (int unsigned k = 0; k < NBYTES; k++) begin
                                if (wstrb_eff[k]) begin
                                    reg_data_n[i*DATA_WIDTH + k*8 +: 8] = wdata_eff[k*8 +: 8];
                                end
                            end
                        end
                    end
                    bresp_n   = w_ok ? RESP_OKAY : RESP_SLVERR;
                    bvalid_n  = 1'b1;
                    awready_n = 1'b0;
                    wready_n  = 1'b0;
                    aw_held_n = 1'b0;
                    w_held_n  = 1'b0;
                    w_state_n = W_RESP;
                end else begin
                    aw_held_n = aw_held || aw_hs;
                    w_held_n  = w_held || w_hs;
                    awready_n = !(aw_held || aw_hs);
                    wready_n  = !(w_held || w_hs);
                end
            end
            W_RESP: begin
                awready_n = 1'b0;
                wready_n  = 1'b0;
                if (s_bready) begin
                    bvalid_n  = 1'b0;
                    awready_n = 1'b1;
                    wready_n  = 1'b1;
                    w_state_n = W_IDLE;
                end
            end
            default: w_state_n = W_IDLE;
        endcase
    end

    // Read channel: sample the source at the AR handshake, hold until taken.
    always_comb begin
        r_state_n  = r_state;
        arready_n  = s_arready;
        rvalid_n   = s_rvalid;
        rdata_n    = s_rdata;
        rresp_n    = s_rresp;
        rd_pulse_n = '0;
        r_hit      = 1'b0;

        case (r_state)
            R_IDLE: begin
                arready_n = 1'b1;
                if (ar_hs) begin
                    rdata_n = '0;
                    for (int unsigned i = 0; i < NREGS; i++) begin
                        if (ridx == IDX_W'(i)) begin
                            r_hit         = 1'b1;
                            rd_pulse_n[i] = 1'b1;
                            rdata_n       = RW_MASK[i] ? reg_data[i*DATA_WIDTH +: DATA_WIDTH]
                                                       : hw_data[i*DATA_WIDTH +: DATA_WIDTH];
                        end
                    end
                    rresp_n   = r_hit ? RESP_OKAY : RESP_SLVERR;
                    rvalid_n  = 1'b1;
                    arready_n = 1'b0;
                    r_state_n = R_DATA;
                end
            end
            R_DATA: begin
                arready_n = 1'b0;
                if (s_rready) begin
                    rvalid_n  = 1'b0;
                    arready_n = 1'b1;
                    r_state_n = R_IDLE;
                end
            end
            default: r_state_n = R_IDLE;
        endcase
    end

endmodule
